// File: rtl/siso_tx_ctrl.sv
// Parallel-to-serial transmit sequencer: accepts a word on valid/ready, shifts it out MSB-first
// with frame markers and a forced idle gap. Define SISO_TX_PARITY_EN to append an even-parity bit.
module siso_tx_ctrl #(
  parameter int N   = 4,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         sdo,
  output logic         sdo_valid,
  output logic         frame_start,
  output logic         frame_end,
  output logic         busy
);

  localparam int MAXNG = (N > GAP) ? N : GAP;
  localparam int CW    = $clog2(MAXNG + 1);
  localparam logic [CW-1:0] CNT_SHIFT = CW'(N - 1);
  localparam logic [CW-1:0] CNT_GAP   = CW'((GAP > 0) ? GAP - 1 : 0);

`ifdef SISO_TX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_PAR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

  state_t         state_q, state_d;
  logic [N-1:0]   sh_q, sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           start_d;
  logic           din_ready_q, din_ready_d;
  logic           sdo_q, sdo_d;
  logic           sdo_valid_q, sdo_valid_d;
  logic           frame_start_q, frame_start_d;
  logic           frame_end_q, frame_end_d;
  logic           busy_q, busy_d;
`ifdef SISO_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
`ifdef SISO_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (din_valid && din_ready_q) begin
          state_d = S_SHIFT;
          sh_d    = din;
          cnt_d   = CNT_SHIFT;
          start_d = 1'b1;
`ifdef SISO_TX_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
      S_SHIFT: begin
        // Rotate rather than zero-fill; bits past the frame are never driven.
        sh_d = {sh_q[N-2:0], sh_q[N-1]};
        if (cnt_q == '0) begin
`ifdef SISO_TX_PARITY_EN
          state_d = S_PAR;
`else
          if (GAP > 0) begin
            state_d = S_GAP;
            cnt_d   = CNT_GAP;
          end else begin
            state_d = S_IDLE;
          end
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef SISO_TX_PARITY_EN
      S_PAR: begin
        if (GAP > 0) begin
          state_d = S_GAP;
          cnt_d   = CNT_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    din_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    frame_start_d = start_d;
`ifdef SISO_TX_PARITY_EN
    sdo_valid_d   = (state_d == S_SHIFT) || (state_d == S_PAR);
    sdo_d         = (state_d == S_SHIFT) ? sh_d[N-1] :
                    (state_d == S_PAR)   ? par_d     : 1'b0;
    frame_end_d   = (state_d == S_PAR);
`else
    sdo_valid_d   = (state_d == S_SHIFT);
    sdo_d         = (state_d == S_SHIFT) ? sh_d[N-1] : 1'b0;
    frame_end_d   = (state_d == S_SHIFT) && (cnt_d == '0);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      sh_q          <= '0;
      cnt_q         <= '0;
      din_ready_q   <= 1'b0;
      sdo_q         <= 1'b0;
      sdo_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef SISO_TX_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      cnt_q         <= cnt_d;
      din_ready_q   <= din_ready_d;
      sdo_q         <= sdo_d;
      sdo_valid_q   <= sdo_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      busy_q        <= busy_d;
`ifdef SISO_TX_PARITY_EN
      par_q         <= par_d;
`endif
    end
  end

  assign din_ready   = din_ready_q;
  assign sdo         = sdo_q;
  assign sdo_valid   = sdo_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_siso_tx_ctrl.sv
// Scoreboard bench for siso_tx_ctrl: main instance N=4/GAP=1, second instance N=4/GAP=0.
module tb_siso_tx_ctrl;

  localparam int N   = 4;
  localparam int GAP = 1;
`ifdef SISO_TX_PARITY_EN
  localparam int PB = 1;
  localparam logic [15:0] G0_BITS = 16'b1010_0_0101_0;
`else
  localparam int PB = 0;
  localparam logic [15:0] G0_BITS = 16'b1010_0101;
`endif
  localparam int FL = N + PB;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] din = '0;
  logic din_valid = 1'b0;
  logic din_ready, sdo, sdo_valid, frame_start, frame_end, busy;

  logic [N-1:0] din0 = '0;
  logic v0 = 1'b0;
  logic rdy0, sdo0, sv0, fs0, fe0, busy0;

  always #5 clk = ~clk;

  siso_tx_ctrl #(.N(N), .GAP(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sdo(sdo), .sdo_valid(sdo_valid),
    .frame_start(frame_start), .frame_end(frame_end), .busy(busy)
  );

  siso_tx_ctrl #(.N(N), .GAP(0)) dut_g0 (
    .clk(clk), .reset_n(reset_n), .din(din0), .din_valid(v0),
    .din_ready(rdy0), .sdo(sdo0), .sdo_valid(sv0),
    .frame_start(fs0), .frame_end(fe0), .busy(busy0)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [2:0] expq[$];
  bit chk_space = 0;
  bit have_end = 0;
  int last_end = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [N-1:0] w);
    for (int i = N - 1; i >= 0; i--)
      expq.push_back({w[i], (i == N - 1) ? 1'b1 : 1'b0, (i == 0 && PB == 0) ? 1'b1 : 1'b0});
    if (PB != 0) expq.push_back({^w, 1'b0, 1'b1});
  endtask

  // Monitor: compares every valid serial bit against the scoreboard.
  always @(negedge clk) begin
    logic [2:0] e;
    if (sdo_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("unexpected_bit", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("bit_sdo_fs_fe", int'({sdo, frame_start, frame_end}), int'(e));
      end
      if (frame_start && chk_space && have_end)
        chk("b2b_spacing", cyc - last_end, GAP + 2);
      if (frame_end) begin
        last_end = cyc;
        have_end = 1;
      end
    end else if (sdo_valid === 1'b0 && (sdo | frame_start | frame_end) === 1'b1) begin
      chk("idle_outputs_quiet", int'({sdo, frame_start, frame_end}), 0);
    end
  end

  task automatic send(input logic [N-1:0] w, input bit hold);
    int t = 0;
    din = w;
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) chk("send_timeout", 1, 0);
    push_frame(w);
    @(negedge clk);
    if (!hold) din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((expq.size() != 0 || din_ready !== 1'b1) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, int'({din_ready, sdo, sdo_valid, frame_start, frame_end, busy}), 0);
  endtask

  initial begin
    int cnt;
    int nb, nstart, nacc, gap0;
    logic [15:0] bits;
    bit pend;

    // Reset held 3 edges with a pending word
    din = 4'hF;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_outs("reset_outputs");
    end
    din_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", int'(din_ready), 1);
    chk("busy_after_release", int'(busy), 0);

    // Single frame, din_ready low window
    send(4'b1011, 0);
    chk("busy_in_frame", int'(busy), 1);
    cnt = 0;
    while (din_ready !== 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    chk("ready_low_cycles", cnt, N + PB + GAP);
    wait_idle();

    // Back-to-back with valid held high
    chk_space = 1;
    have_end = 0;
    send(4'hA, 1);
    send(4'h5, 0);
    wait_idle();
    repeat (4) @(negedge clk);
    chk_space = 0;

    // A few more patterns
    send(4'b0001, 0);
    wait_idle();
    send(4'b1000, 0);
    wait_idle();

    // Mid-frame reset after bit 2
    send(4'b1111, 0);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    expq.delete();
    @(negedge clk);
    chk_reset_outs("midframe_reset_outputs");
    @(negedge clk);
    chk_reset_outs("midframe_reset_hold");
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", int'(din_ready), 1);
    send(4'b0110, 0);
    wait_idle();

    // GAP=0 instance: two words, valid held
    din0 = 4'hA;
    v0 = 1'b1;
    nb = 0; nstart = 0; nacc = 0; gap0 = -1; bits = '0; pend = 0;
    last_end = 0;
    for (int c = 0; c < 40; c++) begin
      if (sv0 === 1'b1) begin
        bits = {bits[14:0], sdo0};
        nb++;
        if (fs0) begin
          nstart++;
          if (nstart == 2) gap0 = c - last_end - 1;
        end
        if (fe0) last_end = c;
      end
      if (pend) begin
        pend = 0;
        if (nacc == 1) din0 = 4'h5;
        else v0 = 1'b0;
      end
      if (v0 && rdy0 === 1'b1) begin
        nacc++;
        pend = 1;
      end
      @(negedge clk);
    end
    chk("g0_accepts", nacc, 2);
    chk("g0_frames", nstart, 2);
    chk("g0_bitcount", nb, 2 * FL);
    chk("g0_serial", int'(bits), int'(G0_BITS));
    chk("g0_nonvalid_between", gap0, 1);

    chk("scoreboard_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
